// File: rtl/pulsegen_sched_pkg.sv
// Shared types and constants for the pulse-generator burst scheduler.
package pulsegen_sched_pkg;

  // Scheduler FSM states; IDLE must stay the all-zero reset encoding.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    ON    = 3'd3,
    OFF   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Saturation value of the overrun counter.
  localparam logic [15:0] OVR_MAX = 16'hFFFF;

  // Depth of the ARM/STOP resynchroniser.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pulsegen_sched_sync.sv
// Generic N-stage flop synchroniser with asynchronous active-low reset.
module synchronizer_n #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pulsegen_sched.sv
// Burst scheduler: after a trigger in ARMED, waits DELAY cycles, then drives
// start_o high for ON cycles and low for OFF cycles, NPULSE times.
//
// Handshake: there is no valid/ready pair here; trig_in is a level that is
// accepted in exactly one cycle (state ARMED, arm_s=1, stop_s=0) and every
// other cycle it is either counted as an overrun (DELAY/ON/OFF/DONE) or
// ignored (IDLE), so the trigger source never needs back-pressure.
module pulsegen_sched
  import pulsegen_sched_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int NBURST_W = 16
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                trig_in,
  output logic                start_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [NBURST_W-1:0] pulse_idx_o,
  output logic [15:0]         overrun_o,
  input  logic [CNT_W-1:0]    DELAY_REG,
  input  logic [CNT_W-1:0]    ON_REG,
  input  logic [CNT_W-1:0]    OFF_REG,
  input  logic [NBURST_W-1:0] NPULSE_REG,
  input  logic                ARM_REG,
  input  logic                STOP_REG,
  output state_t              dbg_state_o
);

  state_t              r_state;
  state_t              w_state_n;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_delay;
  logic [CNT_W-1:0]    r_on;
  logic [CNT_W-1:0]    r_off;
  logic [NBURST_W-1:0] r_npulse;
  logic [NBURST_W-1:0] r_idx;
  logic [15:0]         r_ovr;
  logic                r_start;
  logic                r_busy;
  logic                r_done;

  logic                w_rstn;
  logic [1:0]          w_sync_q;
  logic                w_arm_s;
  logic                w_stop_s;
  logic                w_accept;
  logic                w_idx_inc;
  logic [CNT_W-1:0]    w_on_len;
  logic [CNT_W-1:0]    w_off_len;
  logic                w_busy_state;

  assign w_rstn = ~areset;

  synchronizer_n #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (2)
  ) u_sync (
    .i_clk  (aclk),
    .i_rstn (w_rstn),
    .i_d    ({STOP_REG, ARM_REG}),
    .o_q    (w_sync_q)
  );

  assign w_arm_s  = w_sync_q[0];
  assign w_stop_s = w_sync_q[1];

  // A zero ON/OFF length still holds the phase for one cycle so start always
  // toggles and the generator is re-initialised between pulses.
  assign w_on_len     = (r_on  == '0) ? CNT_W'(1) : r_on;
  assign w_off_len    = (r_off == '0) ? CNT_W'(1) : r_off;
  assign w_busy_state = (r_state == DELAY) || (r_state == ON) || (r_state == OFF);

  // Next-state decode; STOP overrides every transition.
  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_idx_inc = 1'b0;
    if (w_stop_s) begin
      w_state_n = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (w_arm_s) w_state_n = ARMED;
        ARMED: begin
          if (!w_arm_s) begin
            w_state_n = IDLE;
          end else if (trig_in) begin
            w_accept = 1'b1;
            if (NPULSE_REG == '0)     w_state_n = DONE;
            else if (DELAY_REG == '0) w_state_n = ON;
            else                      w_state_n = DELAY;
          end
        end
        DELAY: if (r_cnt == r_delay - CNT_W'(1)) w_state_n = ON;
        ON: begin
          if (r_cnt == w_on_len - CNT_W'(1)) begin
            if (r_idx == r_npulse - NBURST_W'(1)) begin
              w_state_n = DONE;
            end else begin
              w_idx_inc = 1'b1;
              w_state_n = OFF;
            end
          end
        end
        OFF:   if (r_cnt == w_off_len - CNT_W'(1)) w_state_n = ON;
        DONE:  w_state_n = w_arm_s ? ARMED : IDLE;
        default: w_state_n = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_n;
  end

  // Phase counter, latched burst configuration and pulse index.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_cnt    <= '0;
      r_delay  <= '0;
      r_on     <= '0;
      r_off    <= '0;
      r_npulse <= '0;
      r_idx    <= '0;
    end else begin
      if (w_state_n != r_state) r_cnt <= '0;
      else if (w_busy_state)    r_cnt <= r_cnt + CNT_W'(1);
      if (w_accept) begin
        r_delay  <= DELAY_REG;
        r_on     <= ON_REG;
        r_off    <= OFF_REG;
        r_npulse <= NPULSE_REG;
        r_idx    <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + NBURST_W'(1);
      end
    end
  end

  // Saturating count of triggers that arrive while a burst is in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ovr <= '0;
    end else if (r_state == IDLE && w_state_n == ARMED) begin
      r_ovr <= '0;
    end else if (trig_in && (w_busy_state || r_state == DONE) && r_ovr != OVR_MAX) begin
      r_ovr <= r_ovr + 16'd1;
    end
  end

  // Outputs decoded from the next state so they line up with the state itself.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_start <= (w_state_n == ON);
      r_busy  <= (w_state_n == DELAY) || (w_state_n == ON) || (w_state_n == OFF);
      r_done  <= (w_state_n == DONE);
    end
  end

  assign start_o     = r_start;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pulse_idx_o = r_idx;
  assign overrun_o   = r_ovr;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pulsegen_sched.sv
// Self-checking bench for pulsegen_sched: expected per-cycle outputs are
// computed from the burst timing rules and checked by an independent monitor.
module tb_pulsegen_sched;
  import pulsegen_sched_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        aclk = 1'b0;
  logic        areset;
  logic        trig_in;
  logic        start_o, busy_o, done_o;
  logic [15:0] pulse_idx_o;
  logic [15:0] overrun_o;
  logic [31:0] DELAY_REG, ON_REG, OFF_REG;
  logic [15:0] NPULSE_REG;
  logic        ARM_REG, STOP_REG;
  state_t      dbg_state_o;

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  pulsegen_sched #(.CNT_W(32), .NBURST_W(16)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .trig_in     (trig_in),
    .start_o     (start_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pulse_idx_o (pulse_idx_o),
    .overrun_o   (overrun_o),
    .DELAY_REG   (DELAY_REG),
    .ON_REG      (ON_REG),
    .OFF_REG     (OFF_REG),
    .NPULSE_REG  (NPULSE_REG),
    .ARM_REG     (ARM_REG),
    .STOP_REG    (STOP_REG),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];      // {start, busy, done, idx[15:0], ovr[15:0]}
  int          exp_cyc_q[$];  // cycle at which each entry is due
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_idx   = 0;   // model: pulse_idx_o between bursts
  int          m_ovr   = 0;   // model: overrun_o between bursts

  task automatic push_exp(input int c, input logic s, input logic b, input logic d,
                          input logic [15:0] idx, input logic [15:0] ovr);
    exp_q.push_back({s, b, d, idx, ovr});
    exp_cyc_q.push_back(c);
  endtask

  task automatic check(input string nm, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: compares DUT outputs with the entry due this cycle.
  always @(negedge aclk) begin
    logic [34:0] e;
    logic [34:0] a;
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      e = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      a = {start_o, busy_o, done_o, pulse_idx_o, overrun_o};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL sb cyc=%0d got s/b/d=%b%b%b idx=%0d ovr=%0d, expected s/b/d=%b%b%b idx=%0d ovr=%0d",
                 cyc, a[34], a[33], a[32], a[31:16], a[15:0], e[34], e[33], e[32], e[31:16], e[15:0]);
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
      n_tests++;
      n_fail++;
      $display("FAIL sb_slot: entry skipped at cyc %0d", cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain();
    for (int i = 0; i < 90000 && exp_q.size() > 0; i++) @(negedge aclk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic push_quiet(input int n);
    for (int i = 1; i <= n; i++) push_exp(cyc + i, 1'b0, 1'b0, 1'b0, 16'(m_idx), 16'(m_ovr));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic fire(input int d, input int t, input int f, input int n, output int tc);
    @(negedge aclk);
    DELAY_REG  = 32'(d);
    ON_REG     = 32'(t);
    OFF_REG    = 32'(f);
    NPULSE_REG = 16'(n);
    trig_in    = 1'b1;
    tc         = cyc;
  endtask

  function automatic bit is_x(input int o, input int first, input int num);
    return (num > 0) && (o >= first) && (o < first + num);
  endfunction

  // One complete burst from ARMED. Expected waveform is derived from the
  // timing rules: first start at t+1+D, pulse k occupies [k*(T'+F'), k*(T'+F')+T'),
  // done at t+1+D+N*T'+(N-1)*F'. Extra triggers at offsets [x_first, x_first+x_num).
  task automatic run_burst(input int d, input int t, input int f, input int n,
                           input int x_first, input int x_num, input bit scramble);
    int tp, fp, dn, tc, ovr, idx, p, k, r;
    logic s, b, dd;
    wait_drain();
    fire(d, t, f, n, tc);
    tp  = (t == 0) ? 1 : t;
    fp  = (f == 0) ? 1 : f;
    dn  = (n == 0) ? 1 : 1 + d + n * tp + (n - 1) * fp;
    ovr = m_ovr;
    for (int o = 1; o <= dn + 3; o++) begin
      if (is_x(o - 1, x_first, x_num)) ovr = (ovr >= 65535) ? 65535 : ovr + 1;
      if (n == 0) begin
        s = 1'b0; b = 1'b0; dd = (o == 1); idx = 0;
      end else if (o >= dn) begin
        s = 1'b0; b = 1'b0; dd = (o == dn); idx = n - 1;
      end else if (o <= d) begin
        s = 1'b0; b = 1'b1; dd = 1'b0; idx = 0;
      end else begin
        p = o - 1 - d;
        k = p / (tp + fp);
        r = p % (tp + fp);
        s = (r < tp); b = 1'b1; dd = 1'b0;
        idx = s ? k : k + 1;
      end
      push_exp(tc + o, s, b, dd, 16'(idx), 16'(ovr));
    end
    for (int o = 1; o <= dn + 3; o++) begin
      @(negedge aclk);
      trig_in = is_x(o, x_first, x_num);
      if (scramble && o == 2) begin
        DELAY_REG  = $urandom_range(0, 40);
        ON_REG     = $urandom_range(0, 9);
        OFF_REG    = $urandom_range(0, 9);
        NPULSE_REG = 16'($urandom_range(0, 7));
      end
    end
    trig_in = 1'b0;
    m_idx = (n == 0) ? 0 : n - 1;
    m_ovr = ovr;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int tc, d, t, f, n, tp, fp, dn, xf, xn;
    areset = 1'b1; trig_in = 1'b0; ARM_REG = 1'b0; STOP_REG = 1'b0;
    DELAY_REG = '0; ON_REG = '0; OFF_REG = '0; NPULSE_REG = '0;

    // Reset state.
    idle(3);
    check("rst_start", start_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_idx", pulse_idx_o, 0);
    check("rst_ovr", overrun_o, 0);
    check("rst_state", dbg_state_o, IDLE);
    areset = 1'b0;

    // Arm.
    ARM_REG = 1'b1;
    idle(6);
    check("armed_state", dbg_state_o, ARMED);

    // D=0 T=5 F=3 N=3.
    run_burst(0, 5, 3, 3, 0, 0, 1'b1);
    wait_drain();
    check("back_armed", dbg_state_o, ARMED);
    check("idx_end", pulse_idx_o, 2);

    // D=10 T=1 F=0 N=2: 1-cycle pulses, 1-cycle gap, done at +14.
    run_burst(10, 1, 0, 2, 0, 0, 1'b0);
    // N=0: immediate done, no start, no busy.
    run_burst(7, 4, 2, 0, 0, 0, 1'b0);
    // Three extra triggers during a burst.
    run_burst(2, 6, 3, 2, 4, 3, 1'b1);
    wait_drain();
    check("ovr_three", overrun_o, 3);

    // STOP at trigger+20 during a long ON.
    wait_drain();
    fire(0, 100, 0, 1, tc);
    for (int o = 1; o <= 30; o++)
      push_exp(tc + o, (o <= 22), (o <= 22), 1'b0, 16'd0, 16'(m_ovr));
    for (int o = 1; o <= 30; o++) begin
      @(negedge aclk);
      trig_in = 1'b0;
      if (o == 20) STOP_REG = 1'b1;
    end
    m_idx = 0;
    wait_drain();
    check("stop_state", dbg_state_o, IDLE);
    // While STOP holds, a trigger is ignored and not counted.
    push_quiet(8);
    @(negedge aclk); trig_in = 1'b1;
    @(negedge aclk); trig_in = 1'b0;
    idle(7);
    wait_drain();
    check("stop_hold", dbg_state_o, IDLE);
    STOP_REG = 1'b0;
    idle(6);
    m_ovr = 0;
    check("rearm_after_stop", dbg_state_o, ARMED);
    push_quiet(4);
    idle(4);

    // Saturating overrun: 70005 triggers during one long burst.
    run_burst(70010, 1, 0, 1, 1, 70005, 1'b0);
    wait_drain();
    ARM_REG = 1'b0;
    idle(6);
    check("disarm_state", dbg_state_o, IDLE);
    push_quiet(2);
    idle(2);
    ARM_REG = 1'b1;
    idle(6);
    m_ovr = 0;
    push_quiet(3);
    idle(3);

    // Randomised bursts with mid-burst config changes and stray triggers.
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(0, 12);
      t = $urandom_range(0, 6);
      f = $urandom_range(0, 4);
      n = $urandom_range(0, 4);
      tp = (t == 0) ? 1 : t;
      fp = (f == 0) ? 1 : f;
      dn = (n == 0) ? 1 : 1 + d + n * tp + (n - 1) * fp;
      xf = $urandom_range(1, dn);
      xn = $urandom_range(0, 3);
      if (xf + xn - 1 > dn) xn = dn - xf + 1;
      run_burst(d, t, f, n, xf, xn, 1'b1);
    end
    wait_drain();

    // Asynchronous reset during the second ON pulse.
    fire(0, 3, 2, 3, tc);
    @(negedge aclk); trig_in = 1'b0;
    for (int i = 0; i < 20 && cyc < tc + 6; i++) @(negedge aclk);
    check("pre_rst_start", start_o, 1);
    check("pre_rst_idx", pulse_idx_o, 1);
    #2 areset = 1'b1;
    #1;
    check("async_rst_start", start_o, 0);
    check("async_rst_idx", pulse_idx_o, 0);
    check("async_rst_busy", busy_o, 0);
    idle(3);
    areset = 1'b0;
    m_idx = 0;
    m_ovr = 0;
    push_quiet(6);
    @(negedge aclk);
    check("post_rst_state", dbg_state_o, IDLE);
    trig_in = 1'b1;
    @(negedge aclk); trig_in = 1'b0;
    idle(5);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
